// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the cyclic-delay-line TDC: clear, arm, sample,
// repeated until enough valid hits are averaged or the miss limit is hit.
module tdc_meas_ctrl #(
    parameter int CODE_W        = 7,
    parameter int CLR_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 88,
    parameter int AVG_LOG2      = 2,
    parameter int MAX_MISS      = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       tdc_en,
    output logic                       tdc_rst,
    input  logic [CODE_W-1:0]          tdc_code,
    output logic [CODE_W+AVG_LOG2-1:0] result_sum,
    output logic [CODE_W-1:0]          result_avg,
    output logic                       result_err,
    output logic                       result_valid,
    input  logic                       result_ready
);

    localparam int ACC_W   = CODE_W + AVG_LOG2;
    localparam int HIT_W   = AVG_LOG2 + 1;
    localparam int NUM_HIT = 1 << AVG_LOG2;
    localparam int MISS_W  = $clog2(MAX_MISS + 1);
    localparam int CNT_MAX = (SETTLE_CYCLES > CLR_CYCLES) ? SETTLE_CYCLES : CLR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, ARM, SAMPLE, DONE} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cyc_cnt, cyc_cnt_n;
    logic [HIT_W-1:0]    hit_cnt, hit_cnt_n;
    logic [MISS_W-1:0]   miss_cnt, miss_cnt_n;
    logic [ACC_W-1:0]    acc, acc_n;
    logic [ACC_W-1:0]    result_sum_n;
    logic [CODE_W-1:0]   result_avg_n;
    logic                result_err_n;

    // Abort wins over everything in the measuring states; a zero code counts as a miss.
    always_comb begin
        state_n      = state;
        cyc_cnt_n    = cyc_cnt;
        hit_cnt_n    = hit_cnt;
        miss_cnt_n   = miss_cnt;
        acc_n        = acc;
        result_sum_n = result_sum;
        result_avg_n = result_avg;
        result_err_n = result_err;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n    = CLEAR;
                    cyc_cnt_n  = '0;
                    hit_cnt_n  = '0;
                    miss_cnt_n = '0;
                    acc_n      = '0;
                end
            end
            CLEAR: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (cyc_cnt == CNT_W'(CLR_CYCLES - 1)) begin
                    state_n   = ARM;
                    cyc_cnt_n = '0;
                end else begin
                    cyc_cnt_n = cyc_cnt + CNT_W'(1);
                end
            end
            ARM: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (cyc_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_n   = SAMPLE;
                    cyc_cnt_n = '0;
                end else begin
                    cyc_cnt_n = cyc_cnt + CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    if (tdc_code != '0) begin
                        acc_n     = acc + ACC_W'(tdc_code);
                        hit_cnt_n = hit_cnt + HIT_W'(1);
                    end else begin
                        miss_cnt_n = miss_cnt + MISS_W'(1);
                    end
                    if (hit_cnt_n == HIT_W'(NUM_HIT)) begin
                        state_n      = DONE;
                        result_sum_n = acc_n;
                        result_avg_n = CODE_W'(acc_n >> AVG_LOG2);
                        result_err_n = 1'b0;
                    end else if (miss_cnt_n == MISS_W'(MAX_MISS)) begin
                        state_n      = DONE;
                        result_sum_n = acc_n;
                        result_avg_n = CODE_W'(acc_n >> AVG_LOG2);
                        result_err_n = 1'b1;
                    end else begin
                        state_n   = CLEAR;
                        cyc_cnt_n = '0;
                    end
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cyc_cnt      <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            acc          <= '0;
            result_sum   <= '0;
            result_avg   <= '0;
            result_err   <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            tdc_en       <= 1'b0;
            tdc_rst      <= 1'b0;
        end else begin
            state        <= state_n;
            cyc_cnt      <= cyc_cnt_n;
            hit_cnt      <= hit_cnt_n;
            miss_cnt     <= miss_cnt_n;
            acc          <= acc_n;
            result_sum   <= result_sum_n;
            result_avg   <= result_avg_n;
            result_err   <= result_err_n;
            result_valid <= (state_n == DONE);
            busy         <= (state_n != IDLE);
            tdc_en       <= (state_n == ARM);
            tdc_rst      <= (state_n == CLEAR);
        end
    end

endmodule
